dpe_pause_ctrl: RTL and testbench
=================================

# dpe_pause_ctrl

Sequences the DPE multiplexer's pause/idle handshake so the CPU can open a quiescent window for reconfiguring the data-plane pipeline (routing tables, keys). It pauses the input multiplexer, tracks packets still in flight through the pipeline, and grants the update window only once the multiplexer is idle and the pipeline has drained. A drain timeout guarantees the window request never hangs, and a minimum run interval guarantees traffic is not starved between update windows.

## Interface
Parameters:
- CNT_W, 8: width of the in-flight packet counter.
- TIMEOUT_CYC, 65535: maximum cycles spent in PAUSE plus DRAIN before the request is aborted. Must be ≥2 and fit in 16 bits.
- MIN_RUN, 16: minimum RUN cycles after each release before a new request is honoured. Must be <2^16.

Ports:
- clk  in  1  system clock; the one clock for the block.
- rst_n  in  1  reset, asynchronous and active-low.
- upd_req  in  1  CPU update-window request, level; held until the CPU is done.
- upd_grant  out  1  update window open; pipeline is paused and empty.
- upd_timeout  out  1  sticky flag: the last request was aborted by timeout.
- pause  out  1  to the multiplexer pause input.
- mux_idle  in  1  from the multiplexer idle output.
- in_eop  in  1  one-cycle pulse: tlast beat accepted at pipeline ingress (valid & ready & tlast).
- out_eop  in  1  one-cycle pulse: tlast beat accepted at pipeline egress.
- inflight  out  CNT_W  packets currently inside the pipeline.
- cnt_err  out  1  sticky in-flight counter underflow or overflow flag.

## Operation
- The FSM states are RUN, PAUSE, DRAIN, GRANT and RELEASE. Outputs are Moore-decoded from registered state.
  - pause = 1 in PAUSE, DRAIN and GRANT.
  - upd_grant = 1 in GRANT only.
- RUN:
  - Go to PAUSE when all of the following hold: upd_req=1, guard counter = 0, upd_timeout = 0.
  - If upd_req=0, clear upd_timeout.
- PAUSE:
  - If upd_req=0, go to RELEASE (abort, no grant).
  - Otherwise, if mux_idle=1, go to DRAIN.
  - Otherwise, if timer = TIMEOUT_CYC-1, set upd_timeout and go to RELEASE.
- DRAIN:
  - If upd_req=0, go to RELEASE.
  - Otherwise, if mux_idle=1 and inflight=0, go to GRANT.
  - Otherwise, if timer = TIMEOUT_CYC-1, set upd_timeout and go to RELEASE.
- GRANT: stay while upd_req=1. When upd_req=0, go to RELEASE.
- RELEASE: lasts one cycle with pause=0 and upd_grant=0. Load the guard counter with MIN_RUN, then go to RUN.
- Timer (16 bit):
  - Cleared on every entry to PAUSE.
  - Increments each cycle in PAUSE and DRAIN.
  - Does not wrap, because the timeout check fires first.
- Guard counter (16 bit): decrements each cycle in RUN while nonzero. It is 0 after reset.
- In-flight counter: runs in every state, independent of the FSM.
  - in_eop alone: +1.
  - out_eop alone: -1.
  - Both together: unchanged.
  - out_eop when inflight = 0: stays at 0 and sets cnt_err.
  - in_eop alone when inflight = 2^CNT_W-1: saturates and sets cnt_err.
  - cnt_err is cleared only by reset.
- Reset mid-operation: all state returns to reset values immediately, so pause drops asynchronously. The requester must re-request.

## Timing
- Reset values:
  - state = RUN.
  - pause = 0, upd_grant = 0, upd_timeout = 0, cnt_err = 0.
  - inflight = 0, timer = 0, guard = 0.
- Request to pause: upd_req sampled high at edge N (guard = 0) gives pause = 1 from cycle N+1.
- Best-case grant: upd_grant rises 2 cycles after PAUSE entry. This needs mux_idle = 1 in the first PAUSE cycle, then mux_idle = 1 and inflight = 0 in the first DRAIN cycle.
- Release: upd_req sampled low in GRANT gives upd_grant = 0 next cycle (RELEASE). pause is also 0 from that cycle.
- Next request: the earliest new PAUSE entry is MIN_RUN+1 cycles after RELEASE.
- Timeout: a request that never drains leaves PAUSE/DRAIN exactly TIMEOUT_CYC cycles after PAUSE entry. upd_timeout is visible in RELEASE.
- inflight and cnt_err update one cycle after the eop pulses.
- mux_idle is sampled as a level. A packet the multiplexer is still forwarding keeps mux_idle low; pause never truncates a packet.

## Test plan
- No traffic, MIN_RUN=16:
  - Stimulus: raise upd_req at cycle 0 with mux_idle=1 and inflight=0.
  - Required: pause=1 at cycle 1 and upd_grant=1 at cycle 3.
  - Then drop upd_req at cycle 10. Required: upd_grant=0 and pause=0 at cycle 11.
  - Re-raise upd_req at once. Required: pause is not reasserted until cycle 29.
- Drain wait:
  - Stimulus: inflight=3 (three in_eop pulses), request, mux_idle=1.
  - Required: state held in DRAIN with upd_grant=0. Three out_eop pulses then give inflight=0, and upd_grant=1 exactly two cycles after the last out_eop.
- Timeout, TIMEOUT_CYC=100:
  - Stimulus: mux_idle held 0.
  - Required: pause high for exactly 100 cycles, then upd_timeout=1 and upd_grant never asserted.
  - While upd_req stays 1, no new pause. upd_req=0 clears upd_timeout.
- Abort:
  - Stimulus: drop upd_req during DRAIN.
  - Required: RELEASE next cycle, upd_grant stays 0, upd_timeout stays 0.
- Counter edges:
  - Simultaneous in_eop and out_eop at inflight=5: inflight stays 5.
  - out_eop at inflight=0: inflight=0 and cnt_err=1.
  - CNT_W=2, four in_eop pulses: inflight saturates at 3 and cnt_err=1.
- Asynchronous reset:
  - Stimulus: assert rst_n=0 in GRANT.
  - Required: pause, upd_grant, inflight and cnt_err go to 0 without a clock edge. After release, the block is in RUN and grants only on a new request.

Source files
------------

// File: rtl/dpe_pause_ctrl.sv
// Pause/drain sequencer for the DPE data plane.
// Pauses the input mux, waits for it to go idle and for every packet in the
// pipeline to leave, then opens an update window for the CPU. A drain timer
// aborts requests that never drain. A guard interval after each release keeps
// traffic flowing between windows.
module dpe_pause_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 65535,  // >= 2, fits in 16 bits
    parameter int unsigned MIN_RUN     = 16      // < 2^16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_req,
    output logic             upd_grant,
    output logic             upd_timeout,
    output logic             pause,
    input  logic             mux_idle,
    input  logic             in_eop,
    input  logic             out_eop,
    output logic [CNT_W-1:0] inflight,
    output logic             cnt_err
);

    localparam logic [15:0]      TimerLast = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      GuardLoad = 16'(MIN_RUN);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        StRun,
        StPause,
        StDrain,
        StGrant,
        StRelease
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [15:0]      guard_q, guard_d;
    logic             upd_timeout_q, upd_timeout_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             cnt_err_q, cnt_err_d;

    logic             drained;
    logic             timeout_hit;

    assign drained = mux_idle && (inflight_q == '0);

    // Timer expiry only counts when no higher-priority exit applies.
    assign timeout_hit = (timer_q == TimerLast) && upd_req &&
                         (((state_q == StPause) && !mux_idle) ||
                          ((state_q == StDrain) && !drained));

    // State register; async reset drops pause without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (upd_req && (guard_q == '0) && !upd_timeout_q) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (!upd_req) begin
                    state_d = StRelease;
                end else if (mux_idle) begin
                    state_d = StDrain;
                end else if (timeout_hit) begin
                    state_d = StRelease;
                end
            end
            StDrain: begin
                if (!upd_req) begin
                    state_d = StRelease;
                end else if (drained) begin
                    state_d = StGrant;
                end else if (timeout_hit) begin
                    state_d = StRelease;
                end
            end
            StGrant: begin
                if (!upd_req) begin
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        pause     = 1'b0;
        upd_grant = 1'b0;
        case (state_q)
            StPause, StDrain: pause = 1'b1;
            StGrant: begin
                pause     = 1'b1;
                upd_grant = 1'b1;
            end
            default: begin
                pause     = 1'b0;
                upd_grant = 1'b0;
            end
        endcase
    end

    // Drain timer, run guard and sticky timeout flag next-state.
    always_comb begin
        timer_d       = timer_q;
        guard_d       = guard_q;
        upd_timeout_d = upd_timeout_q;

        if ((state_q == StRun) && (state_d == StPause)) begin
            timer_d = '0;
        end else if ((state_q == StPause) || (state_q == StDrain)) begin
            timer_d = timer_q + 16'd1;
        end

        if (state_q == StRelease) begin
            guard_d = GuardLoad;
        end else if ((state_q == StRun) && (guard_q != '0)) begin
            guard_d = guard_q - 16'd1;
        end

        if (timeout_hit) begin
            upd_timeout_d = 1'b1;
        end else if ((state_q == StRun) && !upd_req) begin
            upd_timeout_d = 1'b0;
        end
    end

    // In-flight packet counter; saturates at both ends and flags the event.
    always_comb begin
        inflight_d = inflight_q;
        cnt_err_d  = cnt_err_q;
        case ({in_eop, out_eop})
            2'b10: begin
                if (inflight_q == CntMax) begin
                    cnt_err_d = 1'b1;
                end else begin
                    inflight_d = inflight_q + CntOne;
                end
            end
            2'b01: begin
                if (inflight_q == '0) begin
                    cnt_err_d = 1'b1;
                end else begin
                    inflight_d = inflight_q - CntOne;
                end
            end
            default: begin
                inflight_d = inflight_q;
                cnt_err_d  = cnt_err_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            guard_q       <= '0;
            upd_timeout_q <= 1'b0;
            inflight_q    <= '0;
            cnt_err_q     <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            guard_q       <= guard_d;
            upd_timeout_q <= upd_timeout_d;
            inflight_q    <= inflight_d;
            cnt_err_q     <= cnt_err_d;
        end
    end

    assign upd_timeout = upd_timeout_q;
    assign inflight    = inflight_q;
    assign cnt_err     = cnt_err_q;

endmodule

// File: tb/tb_dpe_pause_ctrl.sv
// Self-checking bench for dpe_pause_ctrl: counter vector table, hand-written
// handshake sequences, and a randomized phase against an arithmetic model.
module tb_dpe_pause_ctrl;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT_CYC = 100;
    localparam int unsigned MIN_RUN     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             upd_req, mux_idle, in_eop, out_eop;
    logic             upd_grant, upd_timeout, pause, cnt_err;
    logic [CNT_W-1:0] inflight;

    logic             b_upd_req, b_mux_idle, b_in_eop, b_out_eop;
    logic             b_upd_grant, b_upd_timeout, b_pause, b_cnt_err;
    logic [1:0]       b_inflight;

    dpe_pause_ctrl #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .MIN_RUN    (MIN_RUN)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_req    (upd_req),
        .upd_grant  (upd_grant),
        .upd_timeout(upd_timeout),
        .pause      (pause),
        .mux_idle   (mux_idle),
        .in_eop     (in_eop),
        .out_eop    (out_eop),
        .inflight   (inflight),
        .cnt_err    (cnt_err)
    );

    dpe_pause_ctrl #(
        .CNT_W      (2),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .MIN_RUN    (MIN_RUN)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_req    (b_upd_req),
        .upd_grant  (b_upd_grant),
        .upd_timeout(b_upd_timeout),
        .pause      (b_pause),
        .mux_idle   (b_mux_idle),
        .in_eop     (b_in_eop),
        .out_eop    (b_out_eop),
        .inflight   (b_inflight),
        .cnt_err    (b_cnt_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic in_eop;
        logic out_eop;
        int   exp_inflight;
        logic exp_err;
    } cnt_vec_t;

    cnt_vec_t tbl[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step_n(2);
        rst_n = 1'b1;
    endtask

    task automatic set_vec(input int i, input logic ie, input logic oe, input int inf,
                           input logic er);
        tbl[i].in_eop       = ie;
        tbl[i].out_eop      = oe;
        tbl[i].exp_inflight = inf;
        tbl[i].exp_err      = er;
    endtask

    // Counter reference: plain saturating arithmetic on an integer.
    task automatic model_cnt(input logic ie, input logic oe, input int maxv,
                             inout int m, inout int e);
        if (ie && !oe) begin
            if (m == maxv) e = 1;
            else m = m + 1;
        end else if (oe && !ie) begin
            if (m == 0) e = 1;
            else m = m - 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int bad, pc, gc, to_at_fall, prev_pause;
        int m_a, e_a, m_b, e_b;

        set_vec(0, 1, 0, 1, 0);   set_vec(1, 1, 0, 2, 0);
        set_vec(2, 1, 0, 3, 0);   set_vec(3, 1, 0, 4, 0);
        set_vec(4, 1, 0, 5, 0);   set_vec(5, 1, 1, 5, 0);
        set_vec(6, 0, 0, 5, 0);   set_vec(7, 0, 1, 4, 0);
        set_vec(8, 0, 1, 3, 0);   set_vec(9, 0, 1, 2, 0);
        set_vec(10, 0, 1, 1, 0);  set_vec(11, 0, 1, 0, 0);
        set_vec(12, 0, 1, 0, 1);  set_vec(13, 1, 1, 0, 1);
        set_vec(14, 1, 0, 1, 1);  set_vec(15, 0, 1, 0, 1);

        upd_req = 0; mux_idle = 1; in_eop = 0; out_eop = 0;
        b_upd_req = 0; b_mux_idle = 0; b_in_eop = 0; b_out_eop = 0;
        rst_n = 1'b1;

        // Reset values
        do_reset();
        check("rst_pause", int'(pause), 0);
        check("rst_grant", int'(upd_grant), 0);
        check("rst_timeout", int'(upd_timeout), 0);
        check("rst_inflight", int'(inflight), 0);
        check("rst_cnt_err", int'(cnt_err), 0);

        // Counter vector table
        for (int i = 0; i < 16; i++) begin
            in_eop  = tbl[i].in_eop;
            out_eop = tbl[i].out_eop;
            step();
            check($sformatf("tbl%0d_inflight", i), int'(inflight), tbl[i].exp_inflight);
            check($sformatf("tbl%0d_cnt_err", i), int'(cnt_err), int'(tbl[i].exp_err));
        end
        in_eop = 0; out_eop = 0;

        // No-traffic grant, release, guard interval
        do_reset();
        mux_idle = 1;
        upd_req  = 1;                       // cycle 0
        step();
        check("c1_pause", int'(pause), 1);
        check("c1_grant", int'(upd_grant), 0);
        step();
        check("c2_grant", int'(upd_grant), 0);
        step();
        check("c3_grant", int'(upd_grant), 1);
        check("c3_pause", int'(pause), 1);
        step_n(7);                          // cycle 10
        check("c10_grant", int'(upd_grant), 1);
        upd_req = 0;
        step();                             // cycle 11
        check("c11_grant", int'(upd_grant), 0);
        check("c11_pause", int'(pause), 0);
        upd_req = 1;
        bad = 0;
        for (int c = 12; c <= 28; c++) begin
            step();
            if (pause) bad++;
        end
        check("guard_pause_early", bad, 0);
        step();                             // cycle 29
        check("c29_pause", int'(pause), 1);
        step_n(2);
        check("c31_grant", int'(upd_grant), 1);
        upd_req = 0;
        step();
        check("rel2_pause", int'(pause), 0);
        step_n(20);

        // Drain wait with three packets in flight
        in_eop = 1;
        step_n(3);
        in_eop = 0;
        check("drain_inflight3", int'(inflight), 3);
        upd_req = 1;
        step_n(6);
        check("drain_hold_pause", int'(pause), 1);
        check("drain_hold_grant", int'(upd_grant), 0);
        out_eop = 1;
        step_n(3);
        out_eop = 0;
        check("drain_inflight0", int'(inflight), 0);
        check("drain_l1_grant", int'(upd_grant), 0);
        step();
        check("drain_l2_grant", int'(upd_grant), 1);
        upd_req = 0;
        step();
        check("drain_rel_grant", int'(upd_grant), 0);
        step_n(20);

        // Timeout with mux never idle
        mux_idle = 0;
        upd_req  = 1;
        pc = 0; gc = 0; to_at_fall = -1; prev_pause = 0;
        for (int i = 0; i < 140; i++) begin
            step();
            if (pause) pc++;
            if (upd_grant) gc++;
            if (prev_pause == 1 && !pause && to_at_fall < 0) to_at_fall = int'(upd_timeout);
            prev_pause = int'(pause);
        end
        check("to_pause_cycles", pc, 100);
        check("to_grant_cycles", gc, 0);
        check("to_flag_at_release", to_at_fall, 1);
        check("to_flag_held", int'(upd_timeout), 1);
        upd_req = 0;
        step();
        check("to_flag_cleared", int'(upd_timeout), 0);
        mux_idle = 1;
        step_n(2);

        // Abort during DRAIN
        in_eop = 1;
        step();
        in_eop = 0;
        upd_req = 1;
        step_n(3);
        check("abort_pause_drain", int'(pause), 1);
        upd_req = 0;
        step();
        check("abort_rel_pause", int'(pause), 0);
        check("abort_rel_grant", int'(upd_grant), 0);
        check("abort_rel_timeout", int'(upd_timeout), 0);
        step();
        check("abort_run_pause", int'(pause), 0);
        out_eop = 1;
        step();
        out_eop = 0;
        step_n(20);

        // Narrow counter saturation
        b_in_eop = 1;
        step_n(4);
        b_in_eop = 0;
        check("sat_inflight", int'(b_inflight), 3);
        check("sat_cnt_err", int'(b_cnt_err), 1);

        // Randomized phase against the counter model
        m_a = int'(inflight); e_a = int'(cnt_err);
        m_b = 3; e_b = 1;
        check("rand_start_a", m_a, 0);
        for (int i = 0; i < 400; i++) begin
            in_eop     = 1'($urandom_range(0, 1));
            out_eop    = 1'($urandom_range(0, 1));
            upd_req    = ($urandom_range(0, 7) != 0);
            mux_idle   = 1'($urandom_range(0, 1));
            b_in_eop   = 1'($urandom_range(0, 1));
            b_out_eop  = 1'($urandom_range(0, 1));
            b_upd_req  = 1'($urandom_range(0, 1));
            b_mux_idle = 1'($urandom_range(0, 1));
            model_cnt(in_eop, out_eop, 255, m_a, e_a);
            model_cnt(b_in_eop, b_out_eop, 3, m_b, e_b);
            step();
            check("rnd_inflight_a", int'(inflight), m_a);
            check("rnd_cnt_err_a", int'(cnt_err), e_a);
            check("rnd_inflight_b", int'(b_inflight), m_b);
            check("rnd_cnt_err_b", int'(b_cnt_err), e_b);
            check("rnd_grant_implies_pause", int'(upd_grant && !pause), 0);
        end
        in_eop = 0; out_eop = 0; b_in_eop = 0; b_out_eop = 0;
        upd_req = 0; b_upd_req = 0; mux_idle = 1;

        // Asynchronous reset while granted
        do_reset();
        out_eop = 1;
        step();
        out_eop = 0;
        upd_req = 1;
        step_n(3);
        check("ar_grant", int'(upd_grant), 1);
        in_eop = 1;
        step_n(2);
        in_eop = 0;
        check("ar_inflight2", int'(inflight), 2);
        check("ar_cnt_err1", int'(cnt_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pause_async", int'(pause), 0);
        check("ar_grant_async", int'(upd_grant), 0);
        check("ar_inflight_async", int'(inflight), 0);
        check("ar_cnt_err_async", int'(cnt_err), 0);
        upd_req = 0;
        step();
        rst_n = 1'b1;
        step_n(3);
        check("ar_run_pause", int'(pause), 0);
        check("ar_run_grant", int'(upd_grant), 0);
        upd_req = 1;
        step();
        check("ar_new_pause", int'(pause), 1);
        step_n(2);
        check("ar_new_grant", int'(upd_grant), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
